mio_bus_responder: RTL

- Memory/IO bus responder on the far end of the CPU's MIO handshake: it answers CPU_MIO requests and drives MIO_ready.
- Decodes the request address into one of four regions: data RAM, GPIO output register, switch input port, or unmapped.
- Inserts a per-region number of wait states, then completes the read or write and pulses MIO_ready.
- Sits between the CPU core and the external synchronous data RAM / board IO.

---
 rtl/mio_pkg.sv | 40 ++++
 rtl/mio_bus_responder_if.sv | 39 +++
 rtl/mio_addr_decode.sv | 43 ++++
 rtl/mio_bus_responder.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/mio_pkg.sv
// ---------------------------------------------------------------------------
// mio_pkg
// Shared types and constants for the MIO bus responder:
//   region_t  - address region selected by the decoder
//   state_t   - responder handshake state
//   GPIO_ADDR / SW_ADDR - word addresses of the two IO registers
//   BADDATA   - read value returned for unmapped addresses
//   eff_wait  - clamps a wait-state parameter to a minimum value
// ---------------------------------------------------------------------------
package mio_pkg;

  typedef enum logic [1:0] {
    REG_RAM      = 2'd0,
    REG_GPIO     = 2'd1,
    REG_SW       = 2'd2,
    REG_UNMAPPED = 2'd3
  } region_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ACK  = 2'd2
  } state_t;

  localparam logic [31:0] GPIO_ADDR = 32'hE000_0000;
  localparam logic [31:0] SW_ADDR   = 32'hF000_0000;
  localparam logic [31:0] BADDATA   = 32'hDEAD_BEEF;

  // Width of the wait-state counter; wait parameters above 255 wrap.
  localparam int CNT_W = 8;

  // Returns max(w, floor_v) truncated to the counter width.
  function automatic logic [CNT_W-1:0] eff_wait(input int w, input int floor_v);
    if (w < floor_v) begin
      return CNT_W'(floor_v);
    end
    return CNT_W'(w);
  endfunction

endpackage

// File: rtl/mio_bus_responder_if.sv
// ---------------------------------------------------------------------------
// mio_bus_responder_if
// CPU side of the MIO handshake.
//   CPU_MIO      - request, held by the CPU until it sees MIO_ready
//   mem_w        - 1 = write, 0 = read
//   addr_bus     - byte address (word accesses only)
//   data_out_cpu - write data from the CPU
//   data_in_cpu  - read data back to the CPU, valid while MIO_ready = 1
//   MIO_ready    - one-cycle completion pulse
// Modports: master = CPU, slave = responder.
// ---------------------------------------------------------------------------
interface mio_bus_responder_if;

  logic        CPU_MIO;
  logic        mem_w;
  logic [31:0] addr_bus;
  logic [31:0] data_out_cpu;
  logic [31:0] data_in_cpu;
  logic        MIO_ready;

  modport master (
    output CPU_MIO,
    output mem_w,
    output addr_bus,
    output data_out_cpu,
    input  data_in_cpu,
    input  MIO_ready
  );

  modport slave (
    input  CPU_MIO,
    input  mem_w,
    input  addr_bus,
    input  data_out_cpu,
    output data_in_cpu,
    output MIO_ready
  );

endinterface

// File: rtl/mio_addr_decode.sv
// ---------------------------------------------------------------------------
// mio_addr_decode
// Combinational address decoder for the MIO responder.
//   addr        in  32        byte address (bits [1:0] are don't-care)
//   region      out region_t  RAM / GPIO / SW / UNMAPPED
//   wait_cycles out CNT_W     wait states to insert before the ACK cycle
// RAM waits are forced to at least 1 so the synchronous RAM has a cycle to
// produce its read data before ACK samples it.
// ---------------------------------------------------------------------------
module mio_addr_decode
  import mio_pkg::*;
#(
  parameter int RAM_AW   = 10,
  parameter int RAM_WAIT = 1,
  parameter int IO_WAIT  = 3
) (
  input  logic [31:0]      addr,
  output region_t          region,
  output logic [CNT_W-1:0] wait_cycles
);

  localparam logic [CNT_W-1:0] RAM_WAIT_EFF = eff_wait(RAM_WAIT, 1);
  localparam logic [CNT_W-1:0] IO_WAIT_EFF  = eff_wait(IO_WAIT, 0);

  // Byte-lane bits play no part in a word-only bus.
  logic unused_byte_lane;
  assign unused_byte_lane = ^addr[1:0];

  always_comb begin
    region = REG_UNMAPPED;
    if (addr[31:RAM_AW+2] == '0) begin
      region = REG_RAM;
    end else if (addr[31:2] == GPIO_ADDR[31:2]) begin
      region = REG_GPIO;
    end else if (addr[31:2] == SW_ADDR[31:2]) begin
      region = REG_SW;
    end
  end

  // Unmapped accesses are timed like IO so a stray access still terminates.
  assign wait_cycles = (region == REG_RAM) ? RAM_WAIT_EFF : IO_WAIT_EFF;

endmodule

// File: rtl/mio_bus_responder.sv
// ---------------------------------------------------------------------------
// mio_bus_responder
// Far end of the CPU MIO handshake. Latches a request in IDLE, inserts the
// region's wait states, then spends exactly one ACK cycle completing the
// access and pulsing MIO_ready.
//   clk      in   system clock, rising edge
//   rst      in   asynchronous active-high reset
//   bus      slave modport of mio_bus_responder_if (CPU handshake)
//   ram_addr out  RAM word address, registered at request latch
//   ram_din  out  RAM write data, only non-zero during the write strobe
//   ram_we   out  RAM write strobe, ACK cycle of a RAM write only
//   ram_dout in   RAM read data, one cycle after ram_addr
//   sw_in    in   board switches
//   gpio_out out  LED/GPIO register
// ---------------------------------------------------------------------------
module mio_bus_responder
  import mio_pkg::*;
#(
  parameter int RAM_WAIT = 1,
  parameter int IO_WAIT  = 3,
  parameter int RAM_AW   = 10
) (
  input  logic              clk,
  input  logic              rst,
  mio_bus_responder_if.slave bus,
  output logic [RAM_AW-1:0] ram_addr,
  output logic [31:0]       ram_din,
  output logic              ram_we,
  input  logic [31:0]       ram_dout,
  input  logic [15:0]       sw_in,
  output logic [31:0]       gpio_out
);

  state_t            state_reg;
  state_t            state_next;
  logic [CNT_W-1:0]  cnt_reg;
  logic [CNT_W-1:0]  cnt_next;

  region_t           region_reg;
  logic              we_reg;
  logic [31:0]       wdata_reg;
  logic [RAM_AW-1:0] ram_addr_reg;
  logic [31:0]       gpio_reg;
  logic [31:0]       rdata_hold_reg;

  region_t           dec_region;
  logic [CNT_W-1:0]  dec_wait;
  logic              take_req;
  logic              ack;
  logic [31:0]       rd_mux;

  mio_addr_decode #(
    .RAM_AW   (RAM_AW),
    .RAM_WAIT (RAM_WAIT),
    .IO_WAIT  (IO_WAIT)
  ) u_decode (
    .addr        (bus.addr_bus),
    .region      (dec_region),
    .wait_cycles (dec_wait)
  );

  assign take_req = (state_reg == ST_IDLE) && bus.CPU_MIO;
  assign ack      = (state_reg == ST_ACK);

  // -------------------------------------------------------------------------
  // Handshake FSM
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    unique case (state_reg)
      ST_IDLE: begin
        if (bus.CPU_MIO) begin
          if (dec_wait == '0) begin
            state_next = ST_ACK;
          end else begin
            // cnt counts the remaining WAIT cycles after this one.
            state_next = ST_WAIT;
            cnt_next   = dec_wait - CNT_W'(1);
          end
        end
      end
      ST_WAIT: begin
        if (cnt_reg == '0) begin
          state_next = ST_ACK;
        end else begin
          cnt_next = cnt_reg - CNT_W'(1);
        end
      end
      ST_ACK: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Request latch: everything the transaction needs is captured here so later
  // changes on the CPU side (or CPU_MIO dropping) cannot disturb it.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      region_reg   <= REG_RAM;
      we_reg       <= 1'b0;
      wdata_reg    <= '0;
      ram_addr_reg <= '0;
    end else if (take_req) begin
      region_reg   <= dec_region;
      we_reg       <= bus.mem_w;
      wdata_reg    <= bus.data_out_cpu;
      ram_addr_reg <= bus.addr_bus[RAM_AW+1:2];
    end
  end

  // -------------------------------------------------------------------------
  // Read data path
  // -------------------------------------------------------------------------
  always_comb begin
    rd_mux = BADDATA;
    unique case (region_reg)
      REG_RAM:      rd_mux = ram_dout;
      REG_GPIO:     rd_mux = gpio_reg;
      REG_SW:       rd_mux = {16'h0000, sw_in};
      REG_UNMAPPED: rd_mux = BADDATA;
      default:      rd_mux = BADDATA;
    endcase
  end

  // The live mux is shown during ACK (RAM data is only valid then); the hold
  // register keeps that value on the bus once the ACK cycle is over.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_hold_reg <= '0;
    end else if (ack && !we_reg) begin
      rdata_hold_reg <= rd_mux;
    end
  end

  // -------------------------------------------------------------------------
  // GPIO register: committed on the ACK -> IDLE edge.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gpio_reg <= '0;
    end else if (ack && we_reg && (region_reg == REG_GPIO)) begin
      gpio_reg <= wdata_reg;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign bus.MIO_ready   = ack;
  assign bus.data_in_cpu = (ack && !we_reg) ? rd_mux : rdata_hold_reg;
  assign ram_we          = ack && we_reg && (region_reg == REG_RAM);
  assign ram_din         = ram_we ? wdata_reg : '0;
  assign ram_addr        = ram_addr_reg;
  assign gpio_out        = gpio_reg;

endmodule
